// File: rtl/lbp_pkg.sv
// Shared types, widths and helpers for the LBP window reader.
package lbp_pkg;

    localparam int unsigned PIX_W  = 12;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned LUMA_W = 6;
    localparam int unsigned CMD_W  = 8;
    localparam int unsigned X_W    = 10;
    localparam int unsigned Y_W    = 9;
    localparam int unsigned K_W    = 4;

    localparam logic [CMD_W-1:0] CMD_READ = 8'h01;
    localparam logic [CMD_W-1:0] CMD_NOP  = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACC  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_EMIT      = 3'd5
    } state_e;

    // RGB444 to luma: R + 2G + B, range 0..60.
    function automatic logic [LUMA_W-1:0] luma(input logic [PIX_W-1:0] pix);
        return LUMA_W'(pix[11:8]) + LUMA_W'({pix[7:4], 1'b0}) + LUMA_W'(pix[3:0]);
    endfunction

endpackage

// File: rtl/lbp_window_reader_addr_gen.sv
// Tracks the current centre (x, y, word address) and produces the read
// address for window index k. Addresses are stepped incrementally.
module lbp_addr_gen
    import lbp_pkg::*;
#(
    parameter int unsigned       WIDTH     = 640,
    parameter int unsigned       HEIGHT    = 480,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [K_W-1:0]    k_i,
    output logic [X_W-1:0]    x_o,
    output logic [Y_W-1:0]    y_o,
    output logic              last_o,
    output logic [ADDR_W-1:0] addr_o
);

    localparam logic [ADDR_W-1:0] W_A     = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] FIRST_A = BASE_ADDR + W_A + ONE_A;
    localparam logic [X_W-1:0]    X_LAST  = X_W'(WIDTH - 2);
    localparam logic [Y_W-1:0]    Y_LAST  = Y_W'(HEIGHT - 2);

    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic [ADDR_W-1:0] centre_q;
    logic              row_end_c;

    assign row_end_c = (x_q == X_LAST);
    assign last_o    = row_end_c && (y_q == Y_LAST);
    assign x_o       = x_q;
    assign y_o       = y_q;

    // Centre position: reloads to (1,1) on frame start, raster-steps after each code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= X_W'(1);
            y_q      <= Y_W'(1);
            centre_q <= FIRST_A;
        end else if (load_i) begin
            x_q      <= X_W'(1);
            y_q      <= Y_W'(1);
            centre_q <= FIRST_A;
        end else if (step_i) begin
            if (row_end_c) begin
                // Skip right border, left border of the next row: +3 words.
                x_q      <= X_W'(1);
                y_q      <= y_q + Y_W'(1);
                centre_q <= centre_q + ADDR_W'(3);
            end else begin
                x_q      <= x_q + X_W'(1);
                centre_q <= centre_q + ONE_A;
            end
        end
    end

    // Address of the next read: the new centre when loading/stepping, else window slot k.
    always_comb begin
        addr_o = centre_q;
        if (load_i) begin
            addr_o = FIRST_A;
        end else if (step_i) begin
            addr_o = row_end_c ? (centre_q + ADDR_W'(3)) : (centre_q + ONE_A);
        end else begin
            case (k_i)
                4'd1:    addr_o = centre_q - W_A - ONE_A;
                4'd2:    addr_o = centre_q - W_A;
                4'd3:    addr_o = centre_q - W_A + ONE_A;
                4'd4:    addr_o = centre_q + ONE_A;
                4'd5:    addr_o = centre_q + W_A + ONE_A;
                4'd6:    addr_o = centre_q + W_A;
                4'd7:    addr_o = centre_q + W_A - ONE_A;
                4'd8:    addr_o = centre_q - ONE_A;
                default: addr_o = centre_q;
            endcase
        end
    end

endmodule

// File: rtl/lbp_window_reader.sv
// Reads each interior pixel's 3x3 window from the frame buffer and emits
// one 8-bit LBP code per centre over a valid/ready stream.
module lbp_window_reader
    import lbp_pkg::*;
#(
    parameter int unsigned       WIDTH     = 640,
    parameter int unsigned       HEIGHT    = 480,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       RD_SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              mem_cmd_valid_o,
    output logic [CMD_W-1:0]  mem_cmd_o,
    output logic [ADDR_W-1:0] mem_r_addr_o,
    input  logic              mem_cmd_done_i,
    input  logic [PIX_W-1:0]  mem_data_out_i,
    output logic              lbp_valid_o,
    input  logic              lbp_ready_i,
    output logic [7:0]        lbp_code_o,
    output logic [X_W-1:0]    lbp_x_o,
    output logic [Y_W-1:0]    lbp_y_o
);

    localparam bit          DEGEN       = (WIDTH < 3) || (HEIGHT < 3);
    localparam int unsigned CNT_W       = (RD_SETTLE > 1) ? $clog2(RD_SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(RD_SETTLE - 1);

    state_e            state_q;
    logic [K_W-1:0]    k_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [LUMA_W-1:0] luma_q;
    logic [6:0]        bits_q;
    logic              busy_q;
    logic              frame_done_q;
    logic              mem_cmd_valid_q;
    logic [CMD_W-1:0]  mem_cmd_q;
    logic [ADDR_W-1:0] mem_r_addr_q;
    logic              lbp_valid_q;
    logic [7:0]        lbp_code_q;
    logic [X_W-1:0]    lbp_x_q;
    logic [Y_W-1:0]    lbp_y_q;

    logic              ag_load_c;
    logic              ag_step_c;
    logic [K_W-1:0]    ag_k_c;
    logic [X_W-1:0]    ag_x;
    logic [Y_W-1:0]    ag_y;
    logic              ag_last;
    logic [ADDR_W-1:0] ag_addr;
    logic              sample_c;
    logic [LUMA_W-1:0] pix_luma_c;
    logic              ge_c;

    // Address generator control: load on an accepted start, step on a non-final handshake.
    assign ag_load_c  = (state_q == ST_IDLE) && start_i && !frame_done_q && !DEGEN;
    assign ag_step_c  = (state_q == ST_EMIT) && lbp_ready_i && !ag_last;
    assign ag_k_c     = k_q + K_W'(1);
    assign sample_c   = (state_q == ST_SETTLE) && (cnt_q == SETTLE_LAST);
    assign pix_luma_c = luma(mem_data_out_i);
    assign ge_c       = (pix_luma_c >= luma_q);

    lbp_addr_gen #(
        .WIDTH     (WIDTH),
        .HEIGHT    (HEIGHT),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (ag_load_c),
        .step_i (ag_step_c),
        .k_i    (ag_k_c),
        .x_o    (ag_x),
        .y_o    (ag_y),
        .last_o (ag_last),
        .addr_o (ag_addr)
    );

    // Read-sequencing FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            k_q             <= '0;
            cnt_q           <= '0;
            luma_q          <= '0;
            bits_q          <= '0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            mem_cmd_valid_q <= 1'b0;
            mem_cmd_q       <= CMD_NOP;
            mem_r_addr_q    <= BASE_ADDR;
            lbp_valid_q     <= 1'b0;
            lbp_code_q      <= '0;
            lbp_x_q         <= '0;
            lbp_y_q         <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A start coinciding with the frame_done pulse is ignored.
                    if (start_i && !frame_done_q) begin
                        if (DEGEN) begin
                            frame_done_q <= 1'b1;
                        end else begin
                            busy_q          <= 1'b1;
                            k_q             <= '0;
                            mem_cmd_valid_q <= 1'b1;
                            mem_cmd_q       <= CMD_READ;
                            mem_r_addr_q    <= ag_addr;
                            state_q         <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // done already low in the first request cycle counts as accepted.
                    if (!mem_cmd_done_i) begin
                        mem_cmd_valid_q <= 1'b0;
                        mem_cmd_q       <= CMD_NOP;
                        state_q         <= ST_WAIT_DONE;
                    end else begin
                        state_q <= ST_WAIT_ACC;
                    end
                end
                ST_WAIT_ACC: begin
                    if (!mem_cmd_done_i) begin
                        mem_cmd_valid_q <= 1'b0;
                        mem_cmd_q       <= CMD_NOP;
                        state_q         <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (mem_cmd_done_i) begin
                        cnt_q   <= '0;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (sample_c) begin
                        if (k_q == K_W'(0)) begin
                            luma_q <= pix_luma_c;
                        end else if (k_q != K_W'(8)) begin
                            bits_q[3'(k_q - K_W'(1))] <= ge_c;
                        end
                        if (k_q != K_W'(8)) begin
                            k_q             <= ag_k_c;
                            mem_cmd_valid_q <= 1'b1;
                            mem_cmd_q       <= CMD_READ;
                            mem_r_addr_q    <= ag_addr;
                            state_q         <= ST_ISSUE;
                        end else begin
                            lbp_code_q  <= {ge_c, bits_q};
                            lbp_x_q     <= ag_x;
                            lbp_y_q     <= ag_y;
                            lbp_valid_q <= 1'b1;
                            state_q     <= ST_EMIT;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_EMIT: begin
                    if (lbp_ready_i) begin
                        lbp_valid_q <= 1'b0;
                        k_q         <= '0;
                        if (ag_last) begin
                            frame_done_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= ST_IDLE;
                        end else begin
                            mem_cmd_valid_q <= 1'b1;
                            mem_cmd_q       <= CMD_READ;
                            mem_r_addr_q    <= ag_addr;
                            state_q         <= ST_ISSUE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign frame_done_o    = frame_done_q;
    assign mem_cmd_valid_o = mem_cmd_valid_q;
    assign mem_cmd_o       = mem_cmd_q;
    assign mem_r_addr_o    = mem_r_addr_q;
    assign lbp_valid_o     = lbp_valid_q;
    assign lbp_code_o      = lbp_code_q;
    assign lbp_x_o         = lbp_x_q;
    assign lbp_y_o         = lbp_y_q;

endmodule

// File: tb/tb_lbp_window_reader.sv
// Scoreboard bench for lbp_window_reader on a 4x4 frame with a behavioural
// memory controller, plus a degenerate 2x4 instance.
module tb_lbp_window_reader;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int RS = 4;

    typedef struct packed {
        logic [7:0] code;
        logic [9:0] x;
        logic [8:0] y;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy_o, frame_done_o, mem_cmd_valid_o, lbp_valid_o;
    logic [7:0]  mem_cmd_o, lbp_code_o;
    logic [18:0] mem_r_addr_o;
    logic        mem_cmd_done;
    logic [11:0] mem_data;
    logic        lbp_ready;
    logic [9:0]  lbp_x_o;
    logic [8:0]  lbp_y_o;

    logic        start_s;
    logic        busy_s, frame_done_s, mem_cmd_valid_s, lbp_valid_s;
    logic [7:0]  mem_cmd_s, lbp_code_s;
    logic [18:0] mem_r_addr_s;
    logic [9:0]  lbp_x_s;
    logic [8:0]  lbp_y_s;

    always #5 clk = ~clk;

    lbp_window_reader #(.WIDTH(W), .HEIGHT(H), .BASE_ADDR(19'd0), .RD_SETTLE(RS)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy_o), .frame_done_o(frame_done_o),
        .mem_cmd_valid_o(mem_cmd_valid_o), .mem_cmd_o(mem_cmd_o), .mem_r_addr_o(mem_r_addr_o),
        .mem_cmd_done_i(mem_cmd_done), .mem_data_out_i(mem_data), .lbp_valid_o(lbp_valid_o),
        .lbp_ready_i(lbp_ready), .lbp_code_o(lbp_code_o), .lbp_x_o(lbp_x_o), .lbp_y_o(lbp_y_o)
    );

    lbp_window_reader #(.WIDTH(2), .HEIGHT(4), .BASE_ADDR(19'd0), .RD_SETTLE(RS)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .start_i(start_s), .busy_o(busy_s), .frame_done_o(frame_done_s),
        .mem_cmd_valid_o(mem_cmd_valid_s), .mem_cmd_o(mem_cmd_s), .mem_r_addr_o(mem_r_addr_s),
        .mem_cmd_done_i(1'b1), .mem_data_out_i(12'h000), .lbp_valid_o(lbp_valid_s),
        .lbp_ready_i(1'b1), .lbp_code_o(lbp_code_s), .lbp_x_o(lbp_x_s), .lbp_y_o(lbp_y_s)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] mem [W*H];
    int dxs [8] = '{-1, 0, 1, 1, 1, 0, -1, -1};
    int dys [8] = '{-1, -1, -1, 0, 1, 1, 1, 0};

    exp_t        exp_q  [$];
    logic [18:0] addr_q [$];

    int rd_count    = 0;
    int codes_frame = 0;
    int bp_mode     = 0;
    int hold_cnt    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic int ref_luma(input logic [11:0] p);
        return int'(p[11:8]) + 2 * int'(p[7:4]) + int'(p[3:0]);
    endfunction

    // Reference: every interior centre in raster order, code and its nine reads.
    task automatic push_frame();
        for (int y = 1; y <= H - 2; y++) begin
            for (int x = 1; x <= W - 2; x++) begin
                exp_t e;
                int   c;
                c = ref_luma(mem[y * W + x]);
                e.code = '0;
                addr_q.push_back(19'(y * W + x));
                for (int k = 0; k < 8; k++) begin
                    int a;
                    a = (y + dys[k]) * W + (x + dxs[k]);
                    addr_q.push_back(19'(a));
                    e.code[k] = (ref_luma(mem[a]) >= c);
                end
                e.x = 10'(x);
                e.y = 9'(y);
                exp_q.push_back(e);
            end
        end
    endtask

    // Behavioural memory controller: random accept and completion delays;
    // data is valid only in the cycle the reader must sample it.
    int          mc_st = 0, lat = 0, sc = 0, acc_dly = 0;
    logic [18:0] lat_addr;
    always @(negedge clk) begin
        if (!rst_n) begin
            mc_st = 0;
            mem_cmd_done = 1'b1;
        end else begin
            case (mc_st)
                0: begin
                    mem_cmd_done = 1'b1;
                    if (mem_cmd_valid_o) begin
                        chk("cmd_code", 32'(mem_cmd_o), 32'h01);
                        if (acc_dly > 0) begin
                            acc_dly--;
                        end else begin
                            mem_cmd_done = 1'b0;
                            mem_data     = 12'($urandom);
                            lat_addr     = mem_r_addr_o;
                            rd_count++;
                            if (addr_q.size() == 0) fail("unexpected_read");
                            else chk("rd_addr", 32'(lat_addr), 32'(addr_q.pop_front()));
                            lat     = $urandom_range(1, 3);
                            acc_dly = $urandom_range(0, 2);
                            mc_st   = 1;
                        end
                    end
                end
                1: begin
                    lat--;
                    if (lat == 0) begin
                        mem_cmd_done = 1'b1;
                        sc = 0;
                        mc_st = 2;
                    end
                end
                2: begin
                    sc++;
                    if (sc == RS) begin
                        mem_data = (lat_addr < 19'(W * H)) ? mem[lat_addr[3:0]] : 12'hxxx;
                        chk("addr_hold", 32'(mem_r_addr_o), 32'(lat_addr));
                        mc_st = 3;
                    end
                end
                default: begin
                    mem_data = 12'($urandom);
                    mc_st = 0;
                end
            endcase
        end
    end

    // Output monitor: drives backpressure, checks stalls and pops the scoreboard.
    logic        stall_seen = 1'b0;
    logic [26:0] held;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_seen = 1'b0;
            lbp_ready  = 1'b1;
        end else begin
            case (bp_mode)
                0: lbp_ready = 1'b1;
                1: lbp_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (lbp_valid_o && hold_cnt < 20) begin
                        lbp_ready = 1'b0;
                        hold_cnt++;
                    end else begin
                        lbp_ready = 1'b1;
                    end
                end
            endcase
            if (stall_seen) begin
                chk("stall_valid", 32'(lbp_valid_o), 32'd1);
                chk("stall_data", 32'({lbp_code_o, lbp_x_o, lbp_y_o}), 32'(held));
                chk("stall_no_read", 32'(mem_cmd_valid_o), 32'd0);
            end
            if (lbp_valid_o && lbp_ready) begin
                stall_seen = 1'b0;
                codes_frame++;
                if (exp_q.size() == 0) fail("unexpected_code");
                else chk("code_xy", 32'({lbp_code_o, lbp_x_o, lbp_y_o}), 32'(exp_q.pop_front()));
            end else if (lbp_valid_o) begin
                stall_seen = 1'b1;
                held = {lbp_code_o, lbp_x_o, lbp_y_o};
            end
            if (frame_done_o) chk("busy_at_done", 32'(busy_o), 32'd0);
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},  32'(busy_o), 32'd0);
        chk({tag, "_done"},  32'(frame_done_o), 32'd0);
        chk({tag, "_cmdv"},  32'(mem_cmd_valid_o), 32'd0);
        chk({tag, "_cmd"},   32'(mem_cmd_o), 32'd0);
        chk({tag, "_addr"},  32'(mem_r_addr_o), 32'd0);
        chk({tag, "_valid"}, 32'(lbp_valid_o), 32'd0);
        chk({tag, "_code"},  32'(lbp_code_o), 32'd0);
        chk({tag, "_x"},     32'(lbp_x_o), 32'd0);
        chk({tag, "_y"},     32'(lbp_y_o), 32'd0);
    endtask

    task automatic run_frame(input int mode);
        int t;
        int rd0;
        bp_mode  = mode;
        hold_cnt = 0;
        push_frame();
        rd0 = rd_count;
        codes_frame = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy_o), 32'd1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!frame_done_o && t < 6000) begin
            @(negedge clk);
            t++;
        end
        if (!frame_done_o) begin
            fail("frame_timeout");
        end else begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("done_one_cycle", 32'(frame_done_o), 32'd0);
            chk("reads_per_frame", 32'(rd_count - rd0), 32'd36);
            chk("codes_per_frame", 32'(codes_frame), 32'd4);
            chk("sb_empty", 32'(exp_q.size()), 32'd0);
            repeat (10) @(negedge clk);
            chk("idle_after_done", 32'(busy_o), 32'd0);
            chk("no_read_after_done", 32'(rd_count - rd0), 32'd36);
        end
    endtask

    task automatic fill(input logic [11:0] v);
        for (int i = 0; i < W * H; i++) mem[i] = v;
    endtask

    initial begin
        int t;
        int rd0;
        logic seen;
        rst_n = 1'b0;
        start = 1'b0;
        start_s = 1'b0;
        lbp_ready = 1'b1;
        mem_cmd_done = 1'b1;
        mem_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Uniform frame: every code 8'hFF.
        fill(12'h888);
        run_frame(0);

        // Bright centre, dark neighbours.
        fill(12'h000);
        mem[5] = 12'hFFF;
        run_frame(0);

        // Alternating neighbours around a mid-grey centre.
        fill(12'h444);
        mem[0] = 12'h333; mem[1] = 12'h555; mem[2] = 12'h333; mem[6]  = 12'h555;
        mem[10] = 12'h333; mem[9] = 12'h555; mem[8] = 12'h333; mem[4] = 12'h555;
        run_frame(0);

        // Long backpressure on the first code of a random frame.
        for (int i = 0; i < W * H; i++) mem[i] = 12'($urandom);
        run_frame(2);

        // Random frames with random backpressure.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < W * H; i++) mem[i] = 12'($urandom);
            run_frame(1);
        end

        // Abort during the fifth read of centre (2,1), then a clean frame.
        fill(12'h888);
        bp_mode = 0;
        push_frame();
        rd0 = rd_count;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (rd_count < rd0 + 14 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (rd_count < rd0 + 14) fail("abort_wait_timeout");
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (3) @(negedge clk);
        exp_q.delete();
        addr_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(0);

        // Degenerate frame: immediate done, no reads.
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        chk("degen_done", 32'(frame_done_s), 32'd1);
        chk("degen_busy", 32'(busy_s), 32'd0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (mem_cmd_valid_s || lbp_valid_s) seen = 1'b1;
        end
        chk("degen_no_activity", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
